// File: rtl/axi4_traffic_master.sv
// AXI4 master traffic generator and self-checker: one INCR burst per start in write, read or write-then-check mode.
// Optional watchdog enabled by defining AXI4_TM_TIMEOUT_EN.
module axi4_traffic_master #(
  parameter int ID             = 0,
  parameter int ID_WIDTH       = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [7:0]              burst_len,
  input  logic [DATA_WIDTH-1:0]   seed,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [7:0]              err_count,
  output logic                    timeout,
  output logic [ID_WIDTH-1:0]     awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ID_WIDTH-1:0]     arid,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_WIDTH-1:0]     rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int                  SIZE = $clog2(DATA_WIDTH/8);
  localparam logic [ID_WIDTH-1:0] ID_V = ID_WIDTH'(ID);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              mode_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [7:0]              len_q, beat_q;
  logic [DATA_WIDTH-1:0]   seed_q, beat_data;
  logic [7:0]              err_q, err_nxt;
  logic [8:0]              err_sum;
  logic [2:0]              r_errs;
  logic                    pass_q, tmo_q, tmo_fire;
  logic                    accept, last_beat, w_hs, r_hs, b_hs, b_err;

  assign accept    = (state == S_IDLE) && start;
  assign beat_data = seed_q + DATA_WIDTH'(beat_q);
  assign last_beat = (beat_q == len_q);
  assign w_hs      = (state == S_W) && wready;
  assign r_hs      = (state == S_R) && rvalid;
  assign b_hs      = (state == S_B) && bvalid;
  assign b_err     = (bresp != 2'b00) || (bid != ID_V);

  // rlast mismatch covers both early and missing rlast; each failing field counts once.
  assign r_errs = 3'(rdata != beat_data) + 3'(rresp != 2'b00) + 3'(rid != ID_V) + 3'(rlast != last_beat);

  always_comb begin
    err_sum = {1'b0, err_q};
    if (b_hs && b_err) err_sum = err_sum + 9'd1;
    if (r_hs)          err_sum = err_sum + 9'(r_errs);
    err_nxt = err_sum[8] ? 8'hff : err_sum[7:0];
  end

`ifdef AXI4_TM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            chan_hs, watching;

  always_comb begin
    chan_hs = 1'b0;
    case (state)
      S_AW:    chan_hs = awready;
      S_W:     chan_hs = wready;
      S_B:     chan_hs = bvalid;
      S_AR:    chan_hs = arready;
      S_R:     chan_hs = rvalid;
      default: chan_hs = 1'b0;
    endcase
  end

  assign watching = (state != S_IDLE) && (state != S_DONE);
  assign tmo_fire = watching && !chan_hs && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                     wd_cnt <= '0;
    else if (!watching || chan_hs) wd_cnt <= '0;
    else                         wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (mode == 2'd1) ? S_AR : S_AW;
      S_AW:    if (awready) state_nxt = S_W;
      S_W:     if (wready && last_beat) state_nxt = S_B;
      S_B:     if (bvalid) state_nxt = (mode_q == 2'd0) ? S_DONE : S_AR;
      S_AR:    if (arready) state_nxt = S_R;
      S_R:     if (rvalid && last_beat) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (tmo_fire) state_nxt = S_DONE;
  end

  always_comb begin
    awvalid = (state == S_AW);
    wvalid  = (state == S_W);
    bready  = (state == S_B);
    arvalid = (state == S_AR);
    rready  = (state == S_R);
    done    = (state == S_DONE);
    busy    = (state != S_IDLE) && (state != S_DONE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q <= '0;
      base_q <= '0;
      len_q  <= '0;
      seed_q <= '0;
      beat_q <= '0;
      err_q  <= '0;
      pass_q <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      err_q <= err_nxt;
      if (accept) begin
        mode_q <= mode;
        base_q <= base_addr;
        len_q  <= burst_len;
        seed_q <= seed;
        beat_q <= '0;
        err_q  <= '0;
        pass_q <= 1'b0;
        tmo_q  <= 1'b0;
      end
      // Counter wraps to 0 after the last beat so R starts clean after W.
      if (w_hs || r_hs) beat_q <= last_beat ? 8'd0 : beat_q + 8'd1;
      if (tmo_fire) tmo_q <= 1'b1;
      // Verdict includes the error from the final B/R beat landing on this same edge.
      if ((state != S_DONE) && (state_nxt == S_DONE))
        pass_q <= (err_nxt == 8'd0) && !tmo_fire;
    end
  end

  assign pass      = pass_q;
  assign err_count = err_q;
  assign timeout   = tmo_q;

  assign awid    = ID_V;
  assign awaddr  = base_q;
  assign awlen   = len_q;
  assign awsize  = 3'(SIZE);
  assign awburst = 2'b01;
  assign wdata   = beat_data;
  assign wstrb   = '1;
  assign wlast   = (state == S_W) && last_beat;
  assign arid    = ID_V;
  assign araddr  = base_q;
  assign arlen   = len_q;
  assign arsize  = 3'(SIZE);
  assign arburst = 2'b01;

endmodule

// File: tb/tb_axi4_traffic_master.sv
// Bench for axi4_traffic_master: a randomly stalling AXI slave with fault injection, checked against expected
// beat data (seed + i) and expected error totals derived from the injected faults.
module tb_axi4_traffic_master;
  localparam int DW  = 64;
  localparam int AW  = 32;
  localparam int IW  = 4;
  localparam int TMO = 16;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            start;
  logic [1:0]      mode;
  logic [AW-1:0]   base_addr;
  logic [7:0]      burst_len;
  logic [DW-1:0]   seed;
  logic            busy, done, pass, timeout;
  logic [7:0]      err_count;
  logic [IW-1:0]   awid, arid, bid, rid;
  logic [AW-1:0]   awaddr, araddr;
  logic [7:0]      awlen, arlen;
  logic [2:0]      awsize, arsize;
  logic [1:0]      awburst, arburst, bresp, rresp;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;

  always #5 CLK = ~CLK;

  axi4_traffic_master #(
    .ID(0), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .mode(mode), .base_addr(base_addr), .burst_len(burst_len),
    .seed(seed), .busy(busy), .done(done), .pass(pass), .err_count(err_count), .timeout(timeout),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // slave configuration
  int stall_pct, corrupt_beat, slverr_beat;
  bit drop_last, bresp_err, busy_starts;

  // observations of the last run
  bit            got_done, done_after, pass_o, pass_after, tmo_o, busy_at_done, busy_after_start;
  logic [7:0]    err_o, aw_len_o, ar_len_o;
  logic [AW-1:0] aw_addr_o, ar_addr_o;
  logic [2:0]    aw_size_o;
  logic [1:0]    aw_burst_o;
  logic [DW/8-1:0] wstrb_and;
  int            n_aw, n_ar, n_r, stab_viol;
  logic [DW-1:0] wdat_q[$];
  bit            wlast_q[$];

  function automatic bit rnd_rdy();
    return int'($urandom_range(99)) >= stall_pct;
  endfunction

  task automatic cfg(input int stall, input int cb, input int sb, input bit dl, input bit be, input bit bs);
    stall_pct = stall; corrupt_beat = cb; slverr_beat = sb; drop_last = dl; bresp_err = be; busy_starts = bs;
  endtask

  // Issue one start and play the slave until done (bounded); records what the DUT did.
  task automatic run_burst(input logic [1:0] m, input logic [AW-1:0] base, input logic [7:0] len,
                           input logic [DW-1:0] sd);
    bit b_pend, r_act, b_hs, r_hs, p_aw, p_w, p_ar, p_wlast;
    int rbeat;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata;
    n_aw = 0; n_ar = 0; n_r = 0; stab_viol = 0; got_done = 0; done_after = 0; pass_after = 0;
    wdat_q.delete(); wlast_q.delete(); wstrb_and = '1;
    b_pend = 0; r_act = 0; b_hs = 0; r_hs = 0; p_aw = 0; p_w = 0; p_ar = 0; p_wlast = 0; rbeat = 0;
    p_awaddr = '0; p_araddr = '0; p_wdata = '0;
    @(negedge CLK);
    mode = m; base_addr = base; burst_len = len; seed = sd; start = 1'b1;
    @(negedge CLK);
    mode = 2'($urandom); base_addr = $urandom; burst_len = 8'($urandom); seed = {$urandom, $urandom};
    busy_after_start = busy;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      start = busy_starts && busy && (cyc % 3 == 1);
      if (p_aw && (awvalid !== 1'b1 || awaddr !== p_awaddr)) stab_viol++;
      if (p_w && (wvalid !== 1'b1 || wdata !== p_wdata || wlast !== p_wlast)) stab_viol++;
      if (p_ar && (arvalid !== 1'b1 || araddr !== p_araddr)) stab_viol++;
      if (done === 1'b1) begin
        got_done = 1; pass_o = pass; err_o = err_count; tmo_o = timeout; busy_at_done = busy;
        @(negedge CLK);
        done_after = done; pass_after = pass;
        break;
      end
      if (b_hs) begin bvalid = 0; b_pend = 0; end
      else if (b_pend && !bvalid && rnd_rdy()) begin
        bvalid = 1; bid = '0; bresp = bresp_err ? 2'b10 : 2'b00;
      end
      b_hs = bvalid && bready;
      if (r_hs) begin rvalid = 0; rbeat++; end
      if (r_act && rbeat <= int'(len) && !rvalid && rnd_rdy()) begin
        rvalid = 1; rid = '0;
        rdata = (m == 2'd1) ? sd + DW'(rbeat) : (rbeat < wdat_q.size() ? wdat_q[rbeat] : '0);
        if (rbeat == corrupt_beat) rdata = rdata ^ 64'h100;
        rresp = (rbeat == slverr_beat) ? 2'b10 : 2'b00;
        rlast = (rbeat == int'(len)) && !drop_last;
      end
      r_hs = rvalid && rready;
      if (r_hs) n_r++;
      awready = rnd_rdy();
      if (awvalid && awready) begin
        n_aw++; aw_addr_o = awaddr; aw_len_o = awlen; aw_size_o = awsize; aw_burst_o = awburst;
      end
      p_aw = awvalid && !awready; p_awaddr = awaddr;
      wready = rnd_rdy();
      if (wvalid && wready) begin
        wdat_q.push_back(wdata); wlast_q.push_back(wlast); wstrb_and = wstrb_and & wstrb;
        if (wdat_q.size() == int'(len) + 1) b_pend = 1;
      end
      p_w = wvalid && !wready; p_wdata = wdata; p_wlast = wlast;
      arready = rnd_rdy();
      if (arvalid && arready) begin n_ar++; ar_addr_o = araddr; ar_len_o = arlen; r_act = 1; rbeat = 0; end
      p_ar = arvalid && !arready; p_araddr = araddr;
      @(negedge CLK);
    end
    start = 0; awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
  endtask

  task automatic test_reset();
    start = 0; mode = 0; base_addr = 0; burst_len = 0; seed = 0;
    awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0; arready = 0;
    rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
    RST = 1;
    repeat (3) @(negedge CLK);
    n_checks++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin n_fail++; $display("FAIL rst_valids: got %b want 00000", {awvalid, wvalid, bready, arvalid, rready}); end
    n_checks++; if ({busy, done, pass, timeout} !== 4'b0) begin n_fail++; $display("FAIL rst_status: got %b want 0000", {busy, done, pass, timeout}); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL rst_err: got %0d want 0", err_count); end
    n_checks++; if ({awaddr, araddr, wdata, wlast} !== '0) begin n_fail++; $display("FAIL rst_payload: got %h %h %h %b want zeros", awaddr, araddr, wdata, wlast); end
    RST = 0;
    @(negedge CLK);
  endtask

  task automatic test_write_basic();
    logic [DW-1:0] sd = 64'hdeadbeefdeadbeef;
    cfg(0, -1, -1, 0, 0, 0);
    run_burst(2'd0, 32'h2, 8'd7, sd);
    n_checks++; if (got_done !== 1'b1) begin n_fail++; $display("FAIL wr_done: got %b want 1", got_done); end
    n_checks++; if (busy_after_start !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b want 1", busy_after_start); end
    n_checks++; if (n_aw !== 1 || aw_addr_o !== 32'h2 || aw_len_o !== 8'd7) begin n_fail++; $display("FAIL wr_aw: got n=%0d addr=%h len=%0d want 1 2 7", n_aw, aw_addr_o, aw_len_o); end
    n_checks++; if (aw_size_o !== 3'd3 || aw_burst_o !== 2'b01 || wstrb_and !== 8'hff) begin n_fail++; $display("FAIL wr_attr: got size=%0d burst=%0d strb=%h want 3 1 ff", aw_size_o, aw_burst_o, wstrb_and); end
    n_checks++; if (wdat_q.size() !== 8) begin n_fail++; $display("FAIL wr_beats: got %0d want 8", wdat_q.size()); end
    for (int i = 0; i < wdat_q.size(); i++) begin
      n_checks++; if (wdat_q[i] !== sd + DW'(i)) begin n_fail++; $display("FAIL wr_data[%0d]: got %h want %h", i, wdat_q[i], sd + DW'(i)); end
      n_checks++; if (wlast_q[i] !== (i == 7)) begin n_fail++; $display("FAIL wr_wlast[%0d]: got %b want %b", i, wlast_q[i], i == 7); end
    end
    n_checks++; if (n_ar !== 0) begin n_fail++; $display("FAIL wr_no_read: got %0d want 0", n_ar); end
    n_checks++; if (pass_o !== 1'b1 || err_o !== 8'd0 || tmo_o !== 1'b0 || busy_at_done !== 1'b0) begin n_fail++; $display("FAIL wr_result: got pass=%b err=%0d tmo=%b busy=%b want 1 0 0 0", pass_o, err_o, tmo_o, busy_at_done); end
    n_checks++; if (done_after !== 1'b0 || pass_after !== 1'b1) begin n_fail++; $display("FAIL wr_pulse: got done=%b pass=%b want 0 1", done_after, pass_after); end
  endtask

  task automatic test_write_read_stall();
    logic [DW-1:0] sd = 64'hdeadbeefdeadbeef;
    cfg(40, -1, -1, 0, 0, 0);
    run_burst(2'd2, 32'h3, 8'd7, sd);
    n_checks++; if (got_done !== 1'b1) begin n_fail++; $display("FAIL wrr_done: got %b want 1", got_done); end
    n_checks++; if (stab_viol !== 0) begin n_fail++; $display("FAIL wrr_stable: got %0d violations want 0", stab_viol); end
    n_checks++; if (n_ar !== 1 || ar_addr_o !== 32'h3 || ar_len_o !== 8'd7 || n_r !== 8) begin n_fail++; $display("FAIL wrr_read: got n=%0d addr=%h len=%0d beats=%0d want 1 3 7 8", n_ar, ar_addr_o, ar_len_o, n_r); end
    for (int i = 0; i < wdat_q.size(); i++) begin
      n_checks++; if (wdat_q[i] !== sd + DW'(i)) begin n_fail++; $display("FAIL wrr_data[%0d]: got %h want %h", i, wdat_q[i], sd + DW'(i)); end
    end
    n_checks++; if (pass_o !== 1'b1 || err_o !== 8'd0) begin n_fail++; $display("FAIL wrr_result: got pass=%b err=%0d want 1 0", pass_o, err_o); end
  endtask

  task automatic test_read_errors();
    cfg(20, 3, 5, 0, 0, 0);
    run_burst(2'd1, 32'h100, 8'd7, {$urandom, $urandom});
    n_checks++; if (got_done !== 1'b1 || n_aw !== 0 || n_r !== 8) begin n_fail++; $display("FAIL rd_flow: got done=%b aw=%0d beats=%0d want 1 0 8", got_done, n_aw, n_r); end
    n_checks++; if (err_o !== 8'd2 || pass_o !== 1'b0) begin n_fail++; $display("FAIL rd_errs: got err=%0d pass=%b want 2 0", err_o, pass_o); end
  endtask

  task automatic test_wrap();
    cfg(0, -1, -1, 0, 0, 0);
    run_burst(2'd0, 32'h0, 8'd0, '1);
    n_checks++; if (wdat_q.size() !== 1) begin n_fail++; $display("FAIL len0_beats: got %0d want 1", wdat_q.size()); end
    else begin
      n_checks++; if (wdat_q[0] !== 64'hffffffffffffffff || wlast_q[0] !== 1'b1) begin n_fail++; $display("FAIL len0_beat: got %h last=%b want ffffffffffffffff 1", wdat_q[0], wlast_q[0]); end
    end
    n_checks++; if (pass_o !== 1'b1) begin n_fail++; $display("FAIL len0_pass: got %b want 1", pass_o); end
    cfg(30, -1, -1, 0, 0, 0);
    run_burst(2'd3, 32'h40, 8'd1, '1);
    n_checks++; if (wdat_q.size() !== 2) begin n_fail++; $display("FAIL wrap_beats: got %0d want 2", wdat_q.size()); end
    else begin
      n_checks++; if (wdat_q[1] !== 64'h0 || wlast_q[1] !== 1'b1 || wlast_q[0] !== 1'b0) begin n_fail++; $display("FAIL wrap_data: got %h last=%b%b want 0 10", wdat_q[1], wlast_q[1], wlast_q[0]); end
    end
    n_checks++; if (n_ar !== 1 || pass_o !== 1'b1 || err_o !== 8'd0) begin n_fail++; $display("FAIL wrap_check: got ar=%0d pass=%b err=%0d want 1 1 0", n_ar, pass_o, err_o); end
  endtask

  task automatic test_missing_rlast();
    cfg(25, -1, -1, 1, 0, 1);
    run_burst(2'd1, 32'h80, 8'd3, {$urandom, $urandom});
    n_checks++; if (n_aw !== 0 || n_ar !== 1 || n_r !== 4) begin n_fail++; $display("FAIL norlast_flow: got aw=%0d ar=%0d beats=%0d want 0 1 4", n_aw, n_ar, n_r); end
    n_checks++; if (err_o !== 8'd1 || pass_o !== 1'b0) begin n_fail++; $display("FAIL norlast_err: got err=%0d pass=%b want 1 0", err_o, pass_o); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      logic [1:0] m = 2'($urandom_range(3));
      logic [7:0] len = 8'($urandom_range(20));
      logic [DW-1:0] sd = {$urandom, $urandom};
      bit has_w, has_r;
      int exp_err;
      cfg($urandom_range(50), int'($urandom_range(len + 3)) - 1, int'($urandom_range(len + 3)) - 1,
          1'($urandom), 1'($urandom), 1'($urandom));
      has_w = (m != 2'd1);
      has_r = (m != 2'd0);
      exp_err = 0;
      if (has_w && bresp_err) exp_err++;
      if (has_r && corrupt_beat >= 0 && corrupt_beat <= int'(len)) exp_err++;
      if (has_r && slverr_beat >= 0 && slverr_beat <= int'(len)) exp_err++;
      if (has_r && drop_last) exp_err++;
      run_burst(m, $urandom, len, sd);
      n_checks++; if (got_done !== 1'b1 || stab_viol !== 0) begin n_fail++; $display("FAIL rnd%0d_flow: got done=%b viol=%0d want 1 0", it, got_done, stab_viol); end
      n_checks++; if (wdat_q.size() !== (has_w ? int'(len) + 1 : 0) || n_r !== (has_r ? int'(len) + 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_beats: got w=%0d r=%0d mode=%0d len=%0d", it, wdat_q.size(), n_r, m, len); end
      for (int i = 0; i < wdat_q.size(); i++) begin
        n_checks++; if (wdat_q[i] !== sd + DW'(i)) begin n_fail++; $display("FAIL rnd%0d_data[%0d]: got %h want %h", it, i, wdat_q[i], sd + DW'(i)); end
      end
      n_checks++; if (err_o !== 8'(exp_err) || pass_o !== (exp_err == 0)) begin n_fail++; $display("FAIL rnd%0d_result: got err=%0d pass=%b want %0d %b", it, err_o, pass_o, exp_err, exp_err == 0); end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit seen, done_seen;
    @(negedge CLK);
    mode = 2'd0; base_addr = 32'h1000; burst_len = 8'd7; seed = {$urandom, $urandom}; start = 1;
    @(negedge CLK);
    start = 0; awready = 1; wready = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (wvalid === 1'b1) seen = 1;
      else @(negedge CLK);
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL midrst_reach_w: got %b want 1", seen); end
    @(negedge CLK);
    #2 RST = 1;
    #1;
    n_checks++; if ({awvalid, wvalid, bready, arvalid, rready, wlast} !== 6'b0) begin n_fail++; $display("FAIL midrst_valids: got %b want 000000", {awvalid, wvalid, bready, arvalid, rready, wlast}); end
    n_checks++; if ({busy, done} !== 2'b0 || wdata !== '0 || awaddr !== '0) begin n_fail++; $display("FAIL midrst_outs: got busy/done=%b wdata=%h awaddr=%h want 0s", {busy, done}, wdata, awaddr); end
    @(negedge CLK);
    RST = 0; awready = 0; wready = 0;
    done_seen = 0;
    repeat (10) begin @(negedge CLK); if (done === 1'b1) done_seen = 1; end
    n_checks++; if (done_seen !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_nodone: got done=%b busy=%b want 0 0", done_seen, busy); end
  endtask

  task automatic test_timeout();
    bit got;
    int stalls;
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
    @(negedge CLK);
    mode = 2'd0; base_addr = 32'h20; burst_len = 8'd3; seed = {$urandom, $urandom}; start = 1;
    @(negedge CLK);
    start = 0;
`ifdef AXI4_TM_TIMEOUT_EN
    got = 0; stalls = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (done === 1'b1) got = 1;
      else begin if (awvalid === 1'b1) stalls++; @(negedge CLK); end
    end
    n_checks++; if (got !== 1'b1 || stalls !== TMO) begin n_fail++; $display("FAIL tmo_fire: got done=%b stalls=%0d want 1 %0d", got, stalls, TMO); end
    n_checks++; if (timeout !== 1'b1 || pass !== 1'b0 || awvalid !== 1'b0) begin n_fail++; $display("FAIL tmo_state: got tmo=%b pass=%b awvalid=%b want 1 0 0", timeout, pass, awvalid); end
`else
    got = 0; stalls = 0;
    repeat (100) begin
      @(negedge CLK);
      if (done === 1'b1) got = 1;
      if (awvalid === 1'b1) stalls++;
    end
    n_checks++; if (got !== 1'b0 || awvalid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL notmo_wait: got done=%b awvalid=%b busy=%b want 0 1 1", got, awvalid, busy); end
    n_checks++; if (stalls !== 100 || timeout !== 1'b0) begin n_fail++; $display("FAIL notmo_hold: got stalls=%0d tmo=%b want 100 0", stalls, timeout); end
    RST = 1;
    @(negedge CLK);
    RST = 0;
`endif
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_read_stall();
    test_read_errors();
    test_wrap();
    test_missing_rlast();
    test_random();
    test_reset_mid_burst();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_traffic_master.md
Name: axi4_traffic_master

Overview:
Parametrised AXI4 master traffic generator and self-checker, the next generation of the fixed-pattern master device used on the NoC AXI4 wrapper benches. It issues one INCR burst per start pulse in write, read, or write-then-read-check mode. Burst length, base address and data seed are set at run time. It reports pass/fail and an error count, so benches no longer peek into slave memories. It sits on one master port of the NoC AXI4 wrapper, clocked on the FPGA-side clock.

Parameters:
ID, 0, constant AWID/ARID driven on every request
ID_WIDTH, 4, width of AXI ID fields
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 64, AXI data width (power of two, >= 8)
TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; sampled only in IDLE
mode  in  2  0=write, 1=read, 2=write-then-read-check, 3=reserved (treated as 2)
base_addr  in  ADDR_WIDTH  burst start address
burst_len  in  8  AXI LEN (beats-1), 0..255
seed  in  DATA_WIDTH  beat i data = seed + i
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of run
pass  out  1  result of last run; held until next start
err_count  out  8  saturating error count of last run
timeout  out  1  watchdog fired in last run
awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1  AW channel
awready  in  1
wdata/wstrb/wlast/wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1/1  W channel
wready  in  1
bid/bresp/bvalid  in  ID_WIDTH/2/1;  bready  out  1  B channel
arid/araddr/arlen/arsize/arburst/arvalid  out  same as AW;  arready  in  1
rid/rdata/rresp/rlast/rvalid  in  ID_WIDTH/DATA_WIDTH/2/1/1;  rready  out  1

Behaviour:
- Reset (RST high, async): state IDLE. All valid/ready outputs, busy, done, pass and timeout are 0. err_count is 0. Address/data outputs are 0.
- start, mode, base_addr, burst_len and seed are latched on the cycle start is accepted in IDLE. Input changes after that are ignored. start while busy is ignored.
- awsize/arsize = log2(DATA_WIDTH/8). awburst/arburst = 2'b01 (INCR). wstrb all ones. awid/arid = ID.
- FSM: IDLE -> (mode 1 ? AR : AW) on start.
  - AW: awvalid=1 until awready. Then W.
  - W: wvalid=1. Beat counter 0..burst_len advances on wvalid&&wready. wdata = seed + beat (mod 2^DATA_WIDTH). wlast=1 on beat burst_len. After the last handshake go to B.
  - B: bready=1. On bvalid: bresp!=OKAY or bid!=ID adds one error. Next state is mode 0 ? DONE : AR.
  - AR: arvalid=1 until arready. Then R.
  - R: rready=1. Each rvalid beat i is compared; each of these adds one error per beat: rdata != seed+i, rresp!=OKAY, rid!=ID, rlast asserted on a non-final beat, rlast missing on the final beat. Exit after beat burst_len.
  - DONE: done=1 for one cycle, busy=0, pass=(err_count==0 && !timeout). Then IDLE.
- Handshake rules: valid never drops before ready; payload is stable while valid&&!ready. No AW/W overlap: W starts only after AW completes. One outstanding transaction at a time.
- err_count saturates at 255 and is cleared on accepted start. Multiple errors on one beat add their total count.
- burst_len=0: single beat with wlast=1 on it, and rlast expected on it.
- Data wrap: seed+i wraps modulo 2^DATA_WIDTH without error.
- Reset mid-burst aborts immediately to IDLE with all valids deasserted. No partial done pulse.

Optional Feature:
AXI4_TM_TIMEOUT_EN:
- With the macro: a watchdog counts consecutive cycles in any non-IDLE/DONE state without a handshake on the active channel. The count resets on every handshake. At TIMEOUT_CYCLES it forces DONE with timeout=1 and pass=0, and all valids and readies deassert.
- Without the macro: no counter is built, timeout is tied to 0, and the FSM waits indefinitely.

Test Plan:
- mode=0, base=0x2, len=7, seed=0xdeadbeefdeadbeef, always-ready slave -> 8 beats with data seed..seed+7, wlast only on beat 7, done pulse, pass=1, err_count=0.
- mode=2, base=0x3, len=7, same seed, memory slave with random ready/valid stalls -> payload stable under stall, readback matches, pass=1.
- mode=1, slave returns beat 3 corrupted and rresp=SLVERR on beat 5 -> err_count=2, pass=0.
- len=0, seed=0xffffffffffffffff -> single beat, wlast=1, data 0xffff...; a following len=1 run has beat 1 data wrap to 0x0 with no error.
- Slave omits rlast on the final beat of len=3 -> err_count=1. start pulses while busy are ignored; RST asserted mid-W clears all outputs on the same edge.
- With AXI4_TM_TIMEOUT_EN, TIMEOUT_CYCLES=16, awready held 0 -> done after 16 cycles with timeout=1, pass=0, awvalid=0. Without the macro the bench sees awvalid still high after 100 cycles.
